// File: rtl/mio_bus_ctrl.sv
// CPU data-port controller: req/ready handshake to the data RAM with read wait states,
// plus a small IO window (switches, LED, seg7, cycle counter, sticky status).
module mio_bus_ctrl #(
  parameter int          RAM_AW  = 12,
  parameter int          RAM_LAT = 1,
  parameter int          SW_W    = 16,
  parameter int          LED_W   = 16,
  parameter logic [31:0] IO_BASE = 32'hFFFF0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              mem_w,
  input  logic [31:0]       cpu_data_addr,
  input  logic [31:0]       cpu_data_out,
  input  logic [2:0]        cpu_data_amp,
  output logic [31:0]       cpu_data_in,
  output logic              cpu_ready,
  input  logic [SW_W-1:0]   sw_i,
  input  logic [31:0]       ram_data_out,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_data_in,
  output logic              ram_we,
  output logic [2:0]        ram_amp,
  output logic [LED_W-1:0]  led_o,
  output logic [31:0]       seg7_data,
  output logic              seg7_we
);

  // state  | meaning
  // IDLE   | waiting for cpu_req; request fields latched on accept
  // ACCESS | RAM/IO access in progress (RAM reads stay RAM_LAT+1 cycles)
  // DONE   | cpu_ready pulse with read data
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, wdata_q, rdata_q, io_rdata;
  logic [2:0]        amp_q, wait_q;
  logic              wr_q;
  logic [SW_W-1:0]   sw_s1, sw_s2, sw_prev;
  logic [LED_W-1:0]  led_q;
  logic [31:0]       seg7_q, cnt_q;
  logic [1:0]        stat_q, stat_d;
  logic              io_hit, in_access, last_cycle, io_wr, io_rd, io_bad;
  logic [7:0]        off;

  assign io_hit     = (addr_q[31:8] == IO_BASE[31:8]);
  assign off        = addr_q[7:0];
  assign in_access  = (state_q == ACCESS);
  assign last_cycle = in_access && (io_hit || wr_q || wait_q == 3'd0);
  assign io_wr      = in_access && io_hit && wr_q;
  assign io_rd      = in_access && io_hit && !wr_q;

  always_comb begin
    io_rdata = '0;
    io_bad   = 1'b0;
    case (off)
      8'h04:   io_rdata = 32'(sw_s2);
      8'h08:   io_rdata = 32'(led_q);
      8'h0C:   io_rdata = seg7_q;
      8'h10:   io_rdata = cnt_q;
      8'h14:   io_rdata = 32'(stat_q);
      default: io_bad   = in_access && io_hit;
    endcase
  end

  // Set beats clear when a switch change lands on the same edge as a STAT read.
  always_comb begin
    stat_d = stat_q;
    if (io_rd && off == 8'h14) stat_d = 2'b00;
    if (sw_s2 != sw_prev)      stat_d[0] = 1'b1;
    if (io_bad)                stat_d[1] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = ACCESS;
      ACCESS:  if (last_cycle) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      amp_q   <= '0;
      wr_q    <= 1'b0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && cpu_req) begin
        addr_q  <= cpu_data_addr;
        wdata_q <= cpu_data_out;
        amp_q   <= cpu_data_amp;
        wr_q    <= mem_w;
        wait_q  <= 3'(RAM_LAT);
      end else if (in_access && wait_q != 3'd0) begin
        wait_q <= wait_q - 3'd1;
      end
      if (last_cycle) rdata_q <= wr_q ? 32'd0 : (io_hit ? io_rdata : ram_data_out);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      sw_prev <= '0;
      led_q   <= '0;
      seg7_q  <= '0;
      cnt_q   <= '0;
      stat_q  <= '0;
    end else begin
      sw_s1   <= sw_i;
      sw_s2   <= sw_s1;
      sw_prev <= sw_s2;
      stat_q  <= stat_d;
      cnt_q   <= (io_wr && off == 8'h10) ? 32'd0 : cnt_q + 32'd1;
      if (io_wr && off == 8'h08) led_q  <= wdata_q[LED_W-1:0];
      if (io_wr && off == 8'h0C) seg7_q <= wdata_q;
    end
  end

  assign cpu_ready   = (state_q == DONE);
  assign cpu_data_in = cpu_ready ? rdata_q : 32'd0;
  assign ram_we      = in_access && !io_hit && wr_q;
  assign ram_addr    = in_access ? addr_q[RAM_AW-1:0] : '0;
  assign ram_data_in = in_access ? wdata_q : 32'd0;
  assign ram_amp     = in_access ? amp_q : 3'd0;
  assign seg7_we     = cpu_ready && wr_q && io_hit && off == 8'h0C;
  assign led_o       = led_q;
  assign seg7_data   = seg7_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Randomized bench for mio_bus_ctrl against a transaction-level model of the IO map and RAM handshake.
module tb_mio_bus_ctrl;
  localparam int          RAM_AW  = 12;
  localparam int          RAM_LAT = 2;
  localparam int          SW_W    = 16;
  localparam int          LED_W   = 16;
  localparam logic [31:0] IO_BASE = 32'hFFFF0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, mem_w = 1'b0;
  logic [31:0]       cpu_data_addr = '0, cpu_data_out = '0, ram_data_out = '0;
  logic [2:0]        cpu_data_amp = '0;
  logic [SW_W-1:0]   sw_i = '0;
  logic [31:0]       cpu_data_in, ram_data_in, seg7_data;
  logic              cpu_ready, ram_we, seg7_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [2:0]        ram_amp;
  logic [LED_W-1:0]  led_o;

  mio_bus_ctrl #(.RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .SW_W(SW_W), .LED_W(LED_W), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .mem_w(mem_w), .cpu_data_addr(cpu_data_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_amp(cpu_data_amp), .cpu_data_in(cpu_data_in),
    .cpu_ready(cpu_ready), .sw_i(sw_i), .ram_data_out(ram_data_out), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_amp(ram_amp), .led_o(led_o),
    .seg7_data(seg7_data), .seg7_we(seg7_we));

  always #5 clk = ~clk;

  // Free-running cycle index; the counter model is (cycle - cycle at which CNT last read 0).
  logic [31:0] cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  int checks = 0;
  int errors = 0;

  logic [LED_W-1:0] led_m  = '0;
  logic [31:0]      seg7_m = '0;
  logic [1:0]       stat_m = '0;
  logic [SW_W-1:0]  sw_m   = '0;
  logic [31:0]      zero_cyc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] amp, input logic [31:0] rram);
    logic        io;
    logic [7:0]  o;
    logic [31:0] exp_rd, req_cyc;
    int          exp_lat, n;
    io = (a[31:8] == IO_BASE[31:8]);
    o  = a[7:0];
    @(negedge clk);
    cpu_req = 1'b1; mem_w = w; cpu_data_addr = a; cpu_data_out = d;
    cpu_data_amp = amp; ram_data_out = rram;
    req_cyc = cyc;
    exp_rd = '0;
    if (!io) begin
      if (!w) exp_rd = rram;
    end else if (w) begin
      case (o)
        8'h08: led_m = d[LED_W-1:0];
        8'h0C: seg7_m = d;
        8'h10: zero_cyc = req_cyc + 32'd2;
        8'h04, 8'h14: ;
        default: stat_m[1] = 1'b1;
      endcase
    end else begin
      case (o)
        8'h04: exp_rd = 32'(sw_m);
        8'h08: exp_rd = 32'(led_m);
        8'h0C: exp_rd = seg7_m;
        8'h10: exp_rd = req_cyc + 32'd1 - zero_cyc;
        8'h14: begin exp_rd = 32'(stat_m); stat_m = 2'b00; end
        default: stat_m[1] = 1'b1;
      endcase
    end
    exp_lat = (!io && !w) ? 2 + RAM_LAT : 2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("ram_we_access", 32'(ram_we), 32'(!io && w));
        check("data_in_idle", cpu_data_in, 32'd0);
        if (!io) begin
          check("ram_addr", 32'(ram_addr), 32'(a[RAM_AW-1:0]));
          check("ram_amp", 32'(ram_amp), 32'(amp));
          check("ram_data_in", ram_data_in, d);
        end
      end
    end while (!cpu_ready && n < 20);
    check("latency", 32'(n), 32'(exp_lat));
    check("rdata", cpu_data_in, exp_rd);
    check("seg7_we", 32'(seg7_we), 32'(io && w && o == 8'h0C));
    check("ram_we_done", 32'(ram_we), 32'd0);
    cpu_req = 1'b0;
    check("led", 32'(led_o), 32'(led_m));
    check("seg7", seg7_data, seg7_m);
  endtask

  task automatic set_sw(input logic [SW_W-1:0] v);
    @(negedge clk);
    if (v != sw_m) stat_m[0] = 1'b1;
    sw_i = v;
    sw_m = v;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [7:0]  o;
    int          k;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_data_in", cpu_data_in, 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_led", 32'(led_o), 32'd0);
    check("rst_seg7", seg7_data, 32'd0);
    check("rst_seg7_we", 32'(seg7_we), 32'd0);
    rst = 1'b0;
    zero_cyc = '0;

    do_access(1'b0, 32'h0000_0100, 32'd0, 3'd0, 32'hDEADBEEF);
    do_access(1'b1, 32'hFFFF_000C, 32'h12345678, 3'd0, 32'd0);
    set_sw(16'h00A5);
    do_access(1'b0, 32'hFFFF_0004, 32'd0, 3'd0, 32'd0);
    do_access(1'b0, 32'hFFFF_0014, 32'd0, 3'd0, 32'd0);
    do_access(1'b0, 32'hFFFF_0014, 32'd0, 3'd0, 32'd0);

    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    zero_cyc = cyc + 32'd2;
    do_access(1'b0, 32'hFFFF_0010, 32'd0, 3'd0, 32'd0);
    do_access(1'b1, 32'hFFFF_0010, 32'h5555_AAAA, 3'd0, 32'd0);
    do_access(1'b0, 32'hFFFF_0010, 32'd0, 3'd0, 32'd0);

    do_access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 3'b010, 32'd0);
    do_access(1'b0, 32'hFFFF_0020, 32'd0, 3'd0, 32'd0);
    do_access(1'b0, 32'hFFFF_0014, 32'd0, 3'd0, 32'd0);

    @(negedge clk);
    cpu_req = 1'b1; mem_w = 1'b1; cpu_data_addr = 32'hFFFF_0008; cpu_data_out = 32'h0000_BEEF;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_ram_we", 32'(ram_we), 32'd0);
    cpu_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t6_ready", 32'(cpu_ready), 32'd0);
      check("t6_led", 32'(led_o), 32'd0);
    end
    rst = 1'b0;
    led_m = '0; seg7_m = '0; zero_cyc = '0;
    stat_m = (sw_m != '0) ? 2'b01 : 2'b00;
    repeat (4) @(negedge clk);
    do_access(1'b1, 32'hFFFF_0008, 32'h0000_1234, 3'd0, 32'd0);
    do_access(1'b0, 32'hFFFF_0014, 32'd0, 3'd0, 32'd0);

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      d = $urandom;
      if (k <= 2) begin
        a = $urandom;
        if (a[31:8] == IO_BASE[31:8]) a = a ^ 32'h0000_0100;
        do_access(1'($urandom), a, d, 3'($urandom), $urandom);
      end else if (k == 3) begin
        set_sw(SW_W'($urandom));
      end else begin
        case (k)
          4: o = 8'h04;
          5: o = 8'h08;
          6: o = 8'h0C;
          7: o = 8'h10;
          8: o = 8'h14;
          default: begin
            o = 8'($urandom);
            while (o == 8'h04 || o == 8'h08 || o == 8'h0C || o == 8'h10 || o == 8'h14)
              o = 8'($urandom);
          end
        endcase
        do_access(1'($urandom), {IO_BASE[31:8], o}, d, 3'($urandom), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
